// File: rtl/bluetooth_pkg.sv
// bluetooth_pkg: shared FSM state type and byte constants for the Bluetooth frame UART transmitter
package bluetooth_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FINISH} state_t;

    localparam int         FRAME_BYTES_DEFAULT = 18;
    localparam logic [7:0] BYTE_NULL           = 8'h00;
    localparam logic [7:0] BYTE_CR             = 8'h0D;
    localparam logic [7:0] BYTE_LF             = 8'h0A;

endpackage

// File: rtl/bluetooth_frame_uart_tx_baud.sv
// uart_baud_tick: free-running bit-period counter; tick marks the last cycle of each UART bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(CLKS_PER_BIT - 1));

    // count 0..CLKS_PER_BIT-1, held at zero while the FSM is not on a bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else
            r_cnt <= (clear || tick) ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/bluetooth_frame_uart_tx.sv
// bluetooth_frame_uart_tx: serializes a zero-padded ASCII frame as 8N1 UART, MSB byte first; BT_CRLF_EN appends CR LF
module bluetooth_frame_uart_tx
    import bluetooth_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BYTES  = FRAME_BYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8*FRAME_BYTES-1:0] frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_done,
    output logic [4:0]               bytes_sent
);

    localparam int FW = 8 * FRAME_BYTES;

    state_t        r_state;
    logic [FW-1:0] r_shreg;
    logic [7:0]    r_byte;
    logic [2:0]    r_bit;
    logic          r_tx;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic [4:0]    r_sent;
    logic          w_tick;
    logic          w_clear;
    logic          w_end;
    logic [7:0]    w_byte;
`ifdef BT_CRLF_EN
    logic          r_tail;
`endif

    assign w_byte  = r_shreg[FW-1 -: 8];
    assign w_clear = !(r_state == START || r_state == DATA || r_state == STOP);
`ifdef BT_CRLF_EN
    // once the CR LF tail is loaded only its trailing zeros may end the frame
    assign w_end   = (w_byte == BYTE_NULL) || (!r_tail && r_sent == 5'(FRAME_BYTES));
`else
    assign w_end   = (w_byte == BYTE_NULL) || (r_sent == 5'(FRAME_BYTES));
`endif

    assign frame_ready = r_ready;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign tx_done     = r_done;
    assign bytes_sent  = r_sent;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // framing FSM: latch frame, pick bytes from the top of the shift register, drive start/data/stop bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_byte  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sent  <= '0;
`ifdef BT_CRLF_EN
            r_tail  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_valid && r_ready) begin
                        r_shreg <= frame_data;
                        r_sent  <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
`ifdef BT_CRLF_EN
                        r_tail  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
`ifdef BT_CRLF_EN
                    if (w_end && r_tail) begin
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_byte  <= w_end ? BYTE_CR : w_byte;
                        r_tx    <= 1'b0;
                        r_state <= START;
                        if (w_end) begin
                            r_shreg <= {BYTE_CR, BYTE_LF, {(FW-16){1'b0}}};
                            r_tail  <= 1'b1;
                        end
                    end
`else
                    if (w_end) begin
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_byte  <= w_byte;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
`endif
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_byte[0];
                        r_byte  <= r_byte >> 1;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx   <= r_byte[0];
                            r_byte <= r_byte >> 1;
                            r_bit  <= r_bit + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_sent  <= r_sent + 5'd1;
                        r_shreg <= r_shreg << 8;
                        r_state <= LOAD;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
